// File: rtl/cordic_rr_scheduler.sv
// cordic_rr_scheduler: round-robin sharing of one pipelined CORDIC sin/cos
// datapath among NUM_REQ requesters. Each requester may have one operation
// in flight; a tag pipeline matched to the CORDIC latency routes each result
// back to its owner's result register.
// Optional build macro QUADRANT_FOLD_EN: folds 90..270 degree angles into the
// +/-90 degree CORDIC range and negates the results on capture.
module cordic_rr_scheduler #(
   parameter int NUM_REQ    = 4,
   parameter int WIDTH      = 16,
   parameter int ANGLE_W    = 32,
   parameter int CORDIC_LAT = 16,
   parameter int GAIN       = 19429
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*ANGLE_W-1:0] req_angle,
   output logic [NUM_REQ-1:0]         rsp_valid,
   input  logic [NUM_REQ-1:0]         rsp_ready,
   output logic [NUM_REQ*WIDTH-1:0]   rsp_cos,
   output logic [NUM_REQ*WIDTH-1:0]   rsp_sin,
   output logic [WIDTH-1:0]           cordic_x,
   output logic [WIDTH-1:0]           cordic_y,
   output logic [ANGLE_W-1:0]         cordic_angle,
   input  logic [WIDTH-1:0]           cordic_cos,
   input  logic [WIDTH-1:0]           cordic_sin
);

   localparam int          TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned NR    = NUM_REQ;

   logic [NUM_REQ-1:0] outstanding;
   logic [NUM_REQ-1:0] rsp_hs;
   logic [NUM_REQ-1:0] grant;
   logic [TAG_W-1:0]   ptr;
   logic [TAG_W-1:0]   grant_idx;
   logic               grant_any;
   logic [ANGLE_W-1:0] sel_angle;
   logic [ANGLE_W-1:0] issue_angle;
   logic [WIDTH-1:0]   cap_cos;
   logic [WIDTH-1:0]   cap_sin;

   logic               pipe_v   [CORDIC_LAT+1];
   logic [TAG_W-1:0]   pipe_tag [CORDIC_LAT+1];
   logic [WIDTH-1:0]   res_cos  [NUM_REQ];
   logic [WIDTH-1:0]   res_sin  [NUM_REQ];

   assign cordic_x  = WIDTH'(GAIN);
   assign cordic_y  = '0;
   assign rsp_hs    = rsp_valid & rsp_ready;
   assign req_ready = grant;
   assign sel_angle = req_angle[grant_idx*ANGLE_W +: ANGLE_W];

   // Round-robin search from ptr over requesters that are valid and idle
   always_comb begin
      int unsigned idx;
      idx       = 0;
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      for (int unsigned k = 0; k < NR; k++) begin
         idx = (32'(ptr) + k) % NR;
         if (!grant_any && !rst && req_valid[idx] && !outstanding[idx]) begin
            grant_any = 1'b1;
            grant_idx = TAG_W'(idx);
         end
      end
      if (grant_any) grant[grant_idx] = 1'b1;
   end

`ifdef QUADRANT_FOLD_EN
   logic issue_neg;
   logic pipe_neg [CORDIC_LAT+1];

   function automatic logic [WIDTH-1:0] neg_sat(input logic [WIDTH-1:0] v);
      if (v == {1'b1, {(WIDTH-1){1'b0}}}) return {1'b0, {(WIDTH-1){1'b1}}};
      return -v;
   endfunction

   // Top two angle bits differing means 90..270 degrees: rotate by 180 degrees
   always_comb begin
      issue_neg   = sel_angle[ANGLE_W-1] ^ sel_angle[ANGLE_W-2];
      issue_angle = sel_angle ^ {issue_neg, {(ANGLE_W-1){1'b0}}};
      cap_cos     = pipe_neg[CORDIC_LAT] ? neg_sat(cordic_cos) : cordic_cos;
      cap_sin     = pipe_neg[CORDIC_LAT] ? neg_sat(cordic_sin) : cordic_sin;
   end

   // Negate flag travels alongside the tag; qualified by pipe_v on use
   always_ff @(posedge clk) begin
      pipe_neg[0] <= issue_neg;
      for (int unsigned k = 1; k <= CORDIC_LAT; k++) pipe_neg[k] <= pipe_neg[k-1];
   end
`else
   // Angle passes straight through; no result correction
   always_comb begin
      issue_angle = sel_angle;
      cap_cos     = cordic_cos;
      cap_sin     = cordic_sin;
   end
`endif

   // Issue, outstanding tracking, tag pipeline and result capture
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr          <= '0;
         outstanding  <= '0;
         cordic_angle <= '0;
         rsp_valid    <= '0;
         for (int unsigned k = 0; k <= CORDIC_LAT; k++) begin
            pipe_v[k]   <= 1'b0;
            pipe_tag[k] <= '0;
         end
         for (int unsigned i = 0; i < NR; i++) begin
            res_cos[i] <= '0;
            res_sin[i] <= '0;
         end
      end else begin
         if (grant_any) begin
            ptr          <= (grant_idx == TAG_W'(NUM_REQ-1)) ? '0 : grant_idx + TAG_W'(1);
            cordic_angle <= issue_angle;
         end
         // grant and handshake never hit the same bit: grant needs outstanding low
         outstanding <= (outstanding | grant) & ~rsp_hs;
         pipe_v[0]   <= grant_any;
         pipe_tag[0] <= grant_idx;
         for (int unsigned k = 1; k <= CORDIC_LAT; k++) begin
            pipe_v[k]   <= pipe_v[k-1];
            pipe_tag[k] <= pipe_tag[k-1];
         end
         for (int unsigned i = 0; i < NR; i++) begin
            if (pipe_v[CORDIC_LAT] && pipe_tag[CORDIC_LAT] == TAG_W'(i)) begin
               rsp_valid[i] <= 1'b1;
               res_cos[i]   <= cap_cos;
               res_sin[i]   <= cap_sin;
            end else if (rsp_hs[i]) begin
               rsp_valid[i] <= 1'b0;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
      assign rsp_cos[g*WIDTH +: WIDTH] = res_cos[g];
      assign rsp_sin[g*WIDTH +: WIDTH] = res_sin[g];
   end

endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// Self-checking bench for cordic_rr_scheduler with a behavioural CORDIC stub
// (fixed angle -> result table, CORDIC_LAT cycle delay).
module tb_cordic_rr_scheduler;

   localparam int LAT = 16;

`ifdef QUADRANT_FOLD_EN
   localparam logic [31:0] A90_ISSUED = 32'hC0000000;
`else
   localparam logic [31:0] A90_ISSUED = 32'h40000000;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req_valid, req_ready, rsp_valid, rsp_ready;
   logic [127:0] req_angle;
   logic [63:0]  rsp_cos, rsp_sin;
   logic [15:0]  cordic_x, cordic_y, cordic_cos, cordic_sin;
   logic [31:0]  cordic_angle;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cordic_rr_scheduler #(.NUM_REQ(4), .WIDTH(16), .ANGLE_W(32), .CORDIC_LAT(LAT), .GAIN(19429)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_angle(req_angle),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_cos(rsp_cos), .rsp_sin(rsp_sin),
      .cordic_x(cordic_x), .cordic_y(cordic_y), .cordic_angle(cordic_angle),
      .cordic_cos(cordic_cos), .cordic_sin(cordic_sin)
   );

   // CORDIC stub: {cos, sin} for the angles the bench uses
   function automatic logic [31:0] cordic_model(input logic [31:0] a);
      logic signed [15:0] c, s;
      case (a)
         32'h00000000: begin c = 16'sd32000;  s = 16'sd0;      end
         32'h20000000: begin c = 16'sd22627;  s = 16'sd22627;  end
         32'h2AAAAAAA: begin c = 16'sd16000;  s = 16'sd27713;  end
         32'h40000000: begin c = 16'sd0;      s = 16'sd32000;  end
         32'hC0000000: begin c = 16'sd0;      s = -16'sd32000; end
         32'hEAAAAAAA: begin c = 16'sd27713;  s = -16'sd16000; end
         32'hD0000000: begin c = -16'sd32768; s = 16'sd100;    end
         default:      begin c = 16'sh1234;   s = 16'sh4321;   end
      endcase
      return {c, s};
   endfunction

   // Delay line: output during cycle n reflects cordic_angle of cycle n-LAT
   logic [31:0] hist [LAT];
   always @(negedge clk) begin
      for (int k = LAT - 1; k > 0; k--) hist[k] <= hist[k-1];
      hist[0] <= cordic_angle;
      {cordic_cos, cordic_sin} <= cordic_model(hist[LAT-1]);
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_near(input string name, input int act, input int exp);
      tests++;
      if (act > exp + 8 || act < exp - 8) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d +/-8 (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int cos_of(input int p);
      logic signed [15:0] v;
      v = rsp_cos[p*16 +: 16];
      return int'(v);
   endfunction

   function automatic int sin_of(input int p);
      logic signed [15:0] v;
      v = rsp_sin[p*16 +: 16];
      return int'(v);
   endfunction

   typedef struct {
      int          port;
      logic [31:0] angle;
      logic [31:0] exp_angle;
      bit          chk_res;
      int          exp_cos;
      int          exp_sin;
   } vec_t;

   vec_t vecs[$];

   // One isolated operation: grant, issued angle, latency, values, hold, handshake
   task automatic do_op(input vec_t v);
      logic [3:0] oh;
      int t0, lat;
      oh = '0;
      oh[v.port] = 1'b1;
      req_angle[v.port*32 +: 32] = v.angle;
      req_valid = oh;
      rsp_ready = '0;
      #1;
      chk("op_grant", 64'(req_ready), 64'(oh));
      t0 = cyc;
      tick();
      req_valid = '0;
      chk("op_issue_angle", 64'(cordic_angle), 64'(v.exp_angle));
      lat = -1;
      for (int n = 0; n < 40 && lat < 0; n++) begin
         if (rsp_valid[v.port]) lat = cyc - t0;
         else tick();
      end
      chk("op_latency", 64'(lat), 64'(LAT + 2));
      if (v.chk_res) begin
         chk_near("op_cos", cos_of(v.port), v.exp_cos);
         chk_near("op_sin", sin_of(v.port), v.exp_sin);
      end
      repeat (3) tick();
      chk("op_hold_valid", 64'(rsp_valid[v.port]), 64'(1));
      if (v.chk_res) chk_near("op_hold_cos", cos_of(v.port), v.exp_cos);
      rsp_ready = oh;
      tick();
      rsp_ready = '0;
      chk("op_after_hs", 64'(rsp_valid[v.port]), 64'(0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, bad;
      int arr [4];
      int gc  [4];
      int cc  [4];
      int cs  [4];
      logic [31:0] cont_ang [4];
      int cont_cos [4];
      int cont_sin [4];

      vecs.push_back('{0, 32'h20000000, 32'h20000000, 1'b1, 22627, 22627});
      vecs.push_back('{1, 32'h00000000, 32'h00000000, 1'b1, 32000, 0});
      vecs.push_back('{2, 32'h40000000, A90_ISSUED,   1'b1, 0, 32000});
      vecs.push_back('{3, 32'h2AAAAAAA, 32'h2AAAAAAA, 1'b1, 16000, 27713});
      vecs.push_back('{1, 32'hEAAAAAAA, 32'hEAAAAAAA, 1'b1, 27713, -16000});
      vecs.push_back('{3, 32'hC0000000, 32'hC0000000, 1'b1, 0, -32000});
`ifdef QUADRANT_FOLD_EN
      vecs.push_back('{2, 32'h6AAAAAAA, 32'hEAAAAAAA, 1'b1, -27713, 16000});
      vecs.push_back('{0, 32'hA0000000, 32'h20000000, 1'b1, -22627, -22627});
      vecs.push_back('{1, 32'h50000000, 32'hD0000000, 1'b1, 32767, -100});
`else
      vecs.push_back('{2, 32'h6AAAAAAA, 32'h6AAAAAAA, 1'b0, 0, 0});
`endif
      cont_ang = '{32'h00000000, 32'h20000000, 32'h2AAAAAAA, 32'h40000000};
      cont_cos = '{32000, 22627, 16000, 0};
      cont_sin = '{0, 22627, 27713, 32000};

      // Reset with requests pending: nothing may be granted
      rst       = 1'b1;
      req_valid = 4'hF;
      rsp_ready = '0;
      req_angle = {4{32'h12345678}};
      repeat (3) tick();
      #1;
      chk("rst_req_ready", 64'(req_ready), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_angle", 64'(cordic_angle), 64'(0));
      chk("rst_x", 64'(cordic_x), 64'(19429));
      chk("rst_y", 64'(cordic_y), 64'(0));
      chk("rst_rsp_cos", rsp_cos, 64'(0));
      rst       = 1'b0;
      req_valid = '0;

      // Contention: ports granted 0,1,2,3 on consecutive cycles
      for (int p = 0; p < 4; p++) begin
         req_angle[p*32 +: 32] = cont_ang[p];
         arr[p] = -1;
      end
      rsp_ready = 4'hF;
      req_valid = 4'hF;
      t0 = cyc;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("cont_grant", 64'(req_ready), 64'(4'b0001 << k));
         tick();
         req_valid[k] = 1'b0;
      end
      for (int n = 0; n < 40; n++) begin
         for (int p = 0; p < 4; p++)
            if (rsp_valid[p] && arr[p] < 0) begin
               arr[p] = cyc - t0;
               cc[p]  = cos_of(p);
               cs[p]  = sin_of(p);
            end
         tick();
      end
      for (int p = 0; p < 4; p++) begin
         chk("cont_arrival", 64'(arr[p]), 64'(p + LAT + 2));
         chk_near("cont_cos", cc[p], cont_cos[p]);
         chk_near("cont_sin", cs[p], cont_sin[p]);
      end

      // Backpressure on port1 while every port keeps requesting
      req_angle = '0;
      req_angle[32 +: 32] = 32'h20000000;
      rsp_ready = 4'b1101;
      req_valid = 4'hF;
      gc  = '{0, 0, 0, 0};
      bad = 0;
      for (int n = 0; n < 70; n++) begin
         #1;
         if ($countones(req_ready) > 1) bad++;
         for (int p = 0; p < 4; p++) if (req_ready[p]) gc[p]++;
         tick();
      end
      chk("bp_onehot", 64'(bad), 64'(0));
      chk("bp_port0_grants", 64'(gc[0]), 64'(4));
      chk("bp_port1_grants", 64'(gc[1]), 64'(1));
      chk("bp_port2_grants", 64'(gc[2]), 64'(4));
      chk("bp_port3_grants", 64'(gc[3]), 64'(4));
      req_valid = 4'b0010;
      repeat (25) tick();
      chk("bp_hold_valid", 64'(rsp_valid[1]), 64'(1));
      chk_near("bp_hold_cos", cos_of(1), 22627);
      chk_near("bp_hold_sin", sin_of(1), 22627);
      rsp_ready = 4'hF;
      #1;
      chk("bp_no_grant_at_R", 64'(req_ready), 64'(0));
      tick();
      #1;
      chk("bp_grant_at_R1", 64'(req_ready), 64'(4'b0010));
      chk("bp_valid_cleared", 64'(rsp_valid[1]), 64'(0));
      tick();
      req_valid = '0;
      repeat (25) tick();
      chk("bp_drained", 64'(rsp_valid), 64'(0));

      // Reset mid-flight discards port2's operation
      req_angle[64 +: 32] = 32'h40000000;
      req_valid = 4'b0100;
      #1;
      chk("mid_grant", 64'(req_ready), 64'(4'b0100));
      t0 = cyc;
      tick();
      req_valid = '0;
      repeat (4) tick();
      rst       = 1'b1;
      req_valid = 4'hF;
      #1;
      chk("mid_rst_ready", 64'(req_ready), 64'(0));
      tick();
      rst       = 1'b0;
      req_valid = '0;
      chk("mid_rst_angle", 64'(cordic_angle), 64'(0));
      chk("mid_rst_valid", 64'(rsp_valid), 64'(0));
      bad = 0;
      while (cyc <= t0 + 40) begin
         if (rsp_valid[2]) bad++;
         tick();
      end
      chk("mid_no_stale_rsp", 64'(bad), 64'(0));

      // Isolated operations from the vector table
      for (int i = 0; i < vecs.size(); i++) do_op(vecs[i]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cordic_rr_scheduler.md
Name: cordic_rr_scheduler

Overview:
Shares one pipelined CORDIC sine/cosine datapath among NUM_REQ requesters. Uses round-robin arbitration, one outstanding operation per requester, and a tag pipeline that tracks the CORDIC latency so each result returns to its owner. Sits between the requester blocks and the CORDIC instance. It drives the CORDIC angle input and the fixed Xin/Yin gain inputs, and captures COSout/SINout.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 16, CORDIC X/Y/result width
ANGLE_W, 32, angle width; full scale 2^32 = 360 degrees
CORDIC_LAT, 16, cycles from cordic_angle change to matching cordic_cos/cordic_sin
GAIN, 19429, Xin value (32000/1.647), gives full-scale output of about 32000

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester grant; at most one bit high per cycle
req_angle  in  NUM_REQ*ANGLE_W  packed angles, requester i at bits [i*ANGLE_W +: ANGLE_W]
rsp_valid  out  NUM_REQ  result available
rsp_ready  in  NUM_REQ  requester consumes result
rsp_cos  out  NUM_REQ*WIDTH  packed signed cosine results
rsp_sin  out  NUM_REQ*WIDTH  packed signed sine results
cordic_x  out  WIDTH  to CORDIC Xin; constant GAIN
cordic_y  out  WIDTH  to CORDIC Yin; constant 0
cordic_angle  out  ANGLE_W  to CORDIC angle
cordic_cos  in  WIDTH  from CORDIC COSout
cordic_sin  in  WIDTH  from CORDIC SINout

Behaviour:
- Eligibility: requester i is eligible when outstanding[i]=0. outstanding[i] sets on accept and clears on the rsp handshake (rsp_valid[i]&rsp_ready[i]).
- Arbitration: combinational round-robin over req_valid & eligible, starting at pointer ptr.
  - req_ready is one-hot or zero and may depend on req_valid in the same cycle.
  - Accept = req_valid[i]&req_ready[i]. At most one accept per cycle.
  - After accepting i, ptr <= (i+1) mod NUM_REQ. ptr holds when nothing is accepted.
- A requester whose outstanding bit clears in cycle T is not granted before T+1.
- Issue: on accept in cycle T, cordic_angle <= req_angle[i] (registered) and is valid from T+1. cordic_angle holds its last value when idle.
- Tag pipeline: CORDIC_LAT+1 stages of {valid, tag[log2 NUM_REQ]}, entered at T+1.
  - At the edge ending cycle T+1+CORDIC_LAT, cordic_cos/sin are captured into result register tag.
  - rsp_valid[tag] is high from T+2+CORDIC_LAT.
  - Fixed latency from accept to rsp_valid is CORDIC_LAT+2. Throughput is one operation per cycle.
- rsp_valid[i] with its rsp_cos/rsp_sin slice holds stable until the handshake. Data changes only on capture.
- Result register i can never be overwritten while valid, because outstanding[i] blocks re-grant. No stall path into the CORDIC is needed.
- Simultaneous events:
  - Capture for i and handshake for i in the same cycle cannot occur.
  - Handshakes on different ports in the same cycle are all honoured.
- Reset (sync, any cycle), effective next edge:
  - ptr=0, outstanding=0, tag pipeline valids=0, rsp_valid=0, rsp_cos/rsp_sin=0, cordic_angle=0.
  - In-flight operations are discarded; CORDIC outputs for them are ignored.
  - req_ready is 0 during the rst cycle.
- cordic_x=GAIN and cordic_y=0 at all times, including reset.

Optional Feature:
QUADRANT_FOLD_EN
- Defined:
  - At issue, if angle[31:30] is 01 or 10 (90 to 270 degrees), cordic_angle = angle + 0x80000000 and a negate flag rides in the tag pipeline.
  - On capture, flagged cos/sin are two's-complement negated. -32768 saturates to +32767.
  - The accepted range becomes the full circle.
- Undefined: the angle passes unchanged and there is no flag. The requester guarantees |angle| <= 90 degrees; results outside that range are unspecified.
- Latency is identical either way.

Test Plan:
- Reset: hold rst 3 cycles -> rsp_valid=0, req_ready=0, cordic_angle=0, cordic_x=19429, cordic_y=0.
- Single op: port0 angle 0x20000000 (45 deg) accepted at T -> rsp_valid[0] first high at T+18, cos=sin=22627 +/-8. Holds until rsp_ready[0].
- Contention: all four ports valid with angles 0, 0x20000000, 0x2AAAAAAA, 0x40000000, and rsp_ready=1111 -> grants ports 0,1,2,3 on consecutive cycles.
  - Results (+/-8): (32000,0), (22627,22627), (16000,27713), (0,32000).
  - Results arrive in the same order, one cycle apart.
- Backpressure: rsp_ready[1]=0 while port1 keeps req_valid -> port1 is never re-granted and its result stays stable.
  - Ports 0/2/3 are each still served once per round.
  - Raise rsp_ready[1] at cycle R -> next grant to port1 no earlier than R+1.
- Reset mid-flight: accept port2 at T, pulse rst at T+5 -> no rsp_valid[2] through T+40. A new request afterwards completes normally.
- With QUADRANT_FOLD_EN: 0x6AAAAAAA (150 deg) -> cordic_angle=0xEAAAAAAA, cos=-27713, sin=16000 (+/-8).
  - Without the macro: cordic_angle=0x6AAAAAAA; results are not checked.
